// File: rtl/lrn_window_engine.sv
// Local response normalization over a captured pixel window: squares are accumulated
// while filling, then each pixel is divided by K + (sum >> ALPHA_SHIFT). Optional: LRN_OVERRUN_DET_EN.
module lrn_window_engine #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned M_WIDTH     = 10,
   parameter int unsigned MAX_WIN     = 16,
   parameter int unsigned FRAC_BITS   = 8,
   parameter int unsigned K_CONST     = 1,
   parameter int unsigned ALPHA_SHIFT = 4
) (
   input  logic                  core_clk,
   input  logic                  reset,
   input  logic [M_WIDTH-1:0]    dim3,
   input  logic                  r_enable,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full_flag,
   output logic                  div_out_valid,
   output logic [DATA_WIDTH-1:0] div_out_data,
   output logic                  normalized_window,
   output logic                  overrun_err
);

   localparam int unsigned IDX_W = $clog2(MAX_WIN);
   localparam int unsigned PTR_W = IDX_W + 1;
   localparam int unsigned SQ_W  = 2 * DATA_WIDTH;
   localparam int unsigned ACC_W = SQ_W + IDX_W;
   localparam int unsigned DEN_W = ACC_W + 1;
   localparam int unsigned Q_W   = DATA_WIDTH + FRAC_BITS;
   localparam int unsigned CNT_W = $clog2(Q_W) + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_DENOM = 3'd2,
      S_DIV   = 3'd3,
      S_OUT   = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   state_e                state_q, state_d;
   logic                  rd_valid_q, rd_valid_d;
   logic [PTR_W-1:0]      win_len_q, win_len_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [DEN_W-1:0]      denom_q, denom_d;
   logic [DEN_W-1:0]      rem_q, rem_d;
   logic [Q_W-1:0]        dvd_q, dvd_d;
   logic [Q_W-1:0]        quo_q, quo_d;
   logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
   logic                  full_flag_q, full_flag_d;
   logic                  div_out_valid_q, div_out_valid_d;
   logic [DATA_WIDTH-1:0] div_out_data_q, div_out_data_d;
   logic                  normalized_window_q, normalized_window_d;
   logic                  overrun_err_q, overrun_err_d;

   logic [DATA_WIDTH-1:0] win_buf_q [MAX_WIN];

   logic                  capture_c;
   logic                  fill_done_c;
   logic [PTR_W-1:0]      fill_cnt_c;
   logic [PTR_W-1:0]      win_len_c;
   logic [SQ_W-1:0]       sq_c;
   logic [DEN_W-1:0]      denom_raw_c;
   logic [DEN_W:0]        rem_sh_c;
   logic                  q_bit_c;

   // Captures are accepted only while filling and never past the buffer depth
   assign capture_c   = rd_valid_q && ((state_q == S_IDLE) || (state_q == S_FILL))
                        && (wr_ptr_q < PTR_W'(MAX_WIN));
   assign fill_cnt_c  = capture_c ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
   assign fill_done_c = (state_q == S_FILL) && (fill_cnt_c >= win_len_q);
   assign sq_c        = SQ_W'(rd_data) * SQ_W'(rd_data);
   assign denom_raw_c = DEN_W'(acc_q >> ALPHA_SHIFT) + DEN_W'(K_CONST);
   assign rem_sh_c    = {rem_q, dvd_q[Q_W-1]};
   assign q_bit_c     = (rem_sh_c >= {1'b0, denom_q});

   always_comb begin
      if (dim3 == '0) begin
         win_len_c = PTR_W'(1);
      end else if (32'(dim3) > MAX_WIN) begin
         win_len_c = PTR_W'(MAX_WIN);
      end else begin
         win_len_c = PTR_W'(dim3);
      end
   end

   // State register
   always_ff @(posedge core_clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (r_enable) state_d = S_FILL;
         S_FILL:  if (fill_done_c) state_d = S_DENOM;
         S_DENOM: state_d = S_DIV;
         S_DIV:   if (div_cnt_q == CNT_W'(Q_W - 1)) state_d = S_OUT;
         S_OUT:   state_d = (rd_ptr_q == (win_len_q - PTR_W'(1))) ? S_DONE : S_DIV;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: window capture, denominator and restoring divider
   always_comb begin
      rd_valid_d = r_enable;
      win_len_d  = win_len_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      acc_d      = acc_q;
      denom_d    = denom_q;
      rem_d      = rem_q;
      dvd_d      = dvd_q;
      quo_d      = quo_q;
      div_cnt_d  = div_cnt_q;

      if ((state_q == S_IDLE) && r_enable) win_len_d = win_len_c;
      if (capture_c) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
         acc_d    = acc_q + ACC_W'(sq_c);
      end
      if (state_q == S_DENOM) denom_d = (denom_raw_c == '0) ? DEN_W'(1) : denom_raw_c;
      if ((state_q == S_OUT) && (state_d == S_DIV)) rd_ptr_d = rd_ptr_q + PTR_W'(1);

      if ((state_d == S_DIV) && (state_q != S_DIV)) begin
         dvd_d     = Q_W'(win_buf_q[rd_ptr_d[IDX_W-1:0]]) << FRAC_BITS;
         rem_d     = '0;
         quo_d     = '0;
         div_cnt_d = '0;
      end else if (state_q == S_DIV) begin
         rem_d     = q_bit_c ? DEN_W'(rem_sh_c - {1'b0, denom_q}) : DEN_W'(rem_sh_c);
         quo_d     = {quo_q[Q_W-2:0], q_bit_c};
         dvd_d     = dvd_q << 1;
         div_cnt_d = div_cnt_q + CNT_W'(1);
      end

      if (state_q == S_DONE) begin
         acc_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   // Output logic, registered so each flag is high for the state it describes
   always_comb begin
      full_flag_d         = (state_d == S_DENOM) || (state_d == S_DIV)
                            || (state_d == S_OUT) || (state_d == S_DONE);
      div_out_valid_d     = (state_d == S_OUT);
      normalized_window_d = (state_d == S_DONE);
      div_out_data_d      = div_out_data_q;
      if ((state_q == S_DIV) && (state_d == S_OUT)) begin
         div_out_data_d = ((quo_d >> DATA_WIDTH) != '0) ? '1 : DATA_WIDTH'(quo_d);
      end
`ifdef LRN_OVERRUN_DET_EN
      overrun_err_d = overrun_err_q | (rd_valid_q && !capture_c
                      && (state_q != S_IDLE) && (state_q != S_FILL));
`else
      overrun_err_d = 1'b0;
`endif
   end

   always_ff @(posedge core_clk) begin
      if (reset) begin
         rd_valid_q          <= 1'b0;
         win_len_q           <= '0;
         wr_ptr_q            <= '0;
         rd_ptr_q            <= '0;
         acc_q               <= '0;
         denom_q             <= '0;
         rem_q               <= '0;
         dvd_q               <= '0;
         quo_q               <= '0;
         div_cnt_q           <= '0;
         full_flag_q         <= 1'b0;
         div_out_valid_q     <= 1'b0;
         div_out_data_q      <= '0;
         normalized_window_q <= 1'b0;
         overrun_err_q       <= 1'b0;
      end else begin
         rd_valid_q          <= rd_valid_d;
         win_len_q           <= win_len_d;
         wr_ptr_q            <= wr_ptr_d;
         rd_ptr_q            <= rd_ptr_d;
         acc_q               <= acc_d;
         denom_q             <= denom_d;
         rem_q               <= rem_d;
         dvd_q               <= dvd_d;
         quo_q               <= quo_d;
         div_cnt_q           <= div_cnt_d;
         full_flag_q         <= full_flag_d;
         div_out_valid_q     <= div_out_valid_d;
         div_out_data_q      <= div_out_data_d;
         normalized_window_q <= normalized_window_d;
         overrun_err_q       <= overrun_err_d;
      end
   end

   // Window buffer storage; contents need no reset since wr_ptr gates every use
   always_ff @(posedge core_clk) begin
      if (capture_c) win_buf_q[wr_ptr_q[IDX_W-1:0]] <= rd_data;
   end

   assign full_flag         = full_flag_q;
   assign div_out_valid     = div_out_valid_q;
   assign div_out_data      = div_out_data_q;
   assign normalized_window = normalized_window_q;
   assign overrun_err       = overrun_err_q;

endmodule

// File: doc/lrn_window_engine.md
LRN_WINDOW_ENGINE -- requirements
Module: lrn_window_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: unsigned pixel width.
REQ-002 SHALL have parameter M_WIDTH, default 10: width of dim3.
REQ-003 SHALL have parameter MAX_WIN, default 16, power of two: window buffer depth.
REQ-004 SHALL have parameter FRAC_BITS, default 8: quotient fractional bits.
REQ-005 SHALL have parameter K_CONST, default 1: denominator bias.
REQ-006 SHALL have parameter ALPHA_SHIFT, default 4: right shift applied to the sum of squares.
REQ-007 SHALL use one clock and a synchronous, active-high reset, with these ports:
- core_clk  in  1: clock.
- reset  in  1: synchronous active-high reset.
- dim3  in  M_WIDTH: window length, sampled on leaving IDLE.
- r_enable  in  1: mapper read strobe; rd_data is valid one cycle later.
- rd_data  in  DATA_WIDTH: memory read data.
- full_flag  out  1: window captured, processing in progress.
- div_out_valid  out  1: one-cycle quotient strobe.
- div_out_data  out  DATA_WIDTH: normalized pixel.
- normalized_window  out  1: one-cycle window-complete pulse.
- overrun_err  out  1: sticky error for a read outside FILL.

Function
REQ-008 SHALL derive rd_valid_q as r_enable registered by one cycle; rd_data SHALL be captured only when rd_valid_q=1.
REQ-009 SHALL run the FSM states IDLE, FILL, DENOM, DIV, OUT, DONE.
REQ-010 In IDLE, r_enable=1 SHALL latch win_len and move to FILL. dim3=0 SHALL give win_len=1, and dim3>MAX_WIN SHALL give win_len=MAX_WIN.
REQ-011 In IDLE or FILL, each rd_valid_q SHALL perform three updates:
- write buf[wr_ptr]=rd_data;
- set acc+=rd_data*rd_data, with acc of width 2*DATA_WIDTH+log2(MAX_WIN), which cannot overflow;
- increment wr_ptr.
REQ-012 When the capture that makes wr_ptr equal win_len occurs, the next cycle SHALL set full_flag=1 and enter DENOM.
REQ-013 DENOM SHALL last one cycle: denom=K_CONST+(acc>>ALPHA_SHIFT), with denom=0 forced to 1.
REQ-014 DIV SHALL compute (buf[rd_ptr]<<FRAC_BITS)/denom using a restoring divider, one quotient bit per cycle, taking exactly Q=DATA_WIDTH+FRAC_BITS cycles.
REQ-015 A quotient exceeding 2^DATA_WIDTH-1 SHALL clamp to all-ones.
REQ-016 OUT SHALL last one cycle with div_out_valid=1 and div_out_data=quotient; div_out_data SHALL hold its value otherwise.
REQ-017 From OUT, the FSM SHALL go to DONE if rd_ptr=win_len-1; otherwise it SHALL increment rd_ptr and return to DIV.
REQ-018 If full_flag rises in cycle T, div_out_valid SHALL assert at T+1+Q, T+2+2Q, and so on.
REQ-019 DONE SHALL last one cycle and SHALL do all of the following:
- set normalized_window=1;
- clear full_flag, acc, wr_ptr and rd_ptr;
- go to IDLE.
REQ-020 Captures (rd_valid_q=1) in DENOM, DIV, OUT or DONE SHALL be dropped without disturbing buffer, acc or outputs.
REQ-021 Once set, overrun_err SHALL remain 1 until reset.
REQ-022 full_flag SHALL be a level signal from DENOM entry through DONE inclusive.

Reset
REQ-023 On reset, the following SHALL take effect at the next core_clk edge, and this SHALL hold in any state:
- state=IDLE;
- full_flag=0, div_out_valid=0, div_out_data=0, normalized_window=0, overrun_err=0;
- acc, pointers, win_len and rd_valid_q cleared.
REQ-024 Reset during DIV SHALL discard the partial quotient; no div_out_valid SHALL follow.

Configuration
REQ-025 Macro LRN_OVERRUN_DET_EN defined: overrun_err SHALL behave per REQ-020 and REQ-021.
REQ-026 Macro LRN_OVERRUN_DET_EN undefined: overrun_err SHALL be tied 0 and dropped captures SHALL be silent; all other behaviour SHALL be identical.

Verification
REQ-027 Defaults, dim3=4, data 16,16,16,16 -> denom=65; four div_out_data=63 at T+25, T+50, T+75, T+100; normalized_window at T+101.
REQ-028 dim3=3, data 0,4,8 -> acc=80, denom=6; outputs 0, 170, 341 in order.
REQ-029 dim3=20, twenty reads -> full_flag after the 16th capture; 16 outputs; the 4 extra captures raise overrun_err=1 (macro defined) or leave it 0 (undefined).
REQ-030 dim3=0, one read of 4 -> acc=16, denom=2, one output 512, then normalized_window.
REQ-031 reset asserted mid-DIV of window 1 -> no div_out_valid; a new window dim3=1, data 1 -> output 256.
REQ-032 dim3=2 with back-to-back windows, second r_enable one cycle after normalized_window -> second window captured correctly, no overrun_err.
